// File: rtl/gmii_pkg.sv
// Shared constants and FSM encoding for the GMII transmit scheduler.
package gmii_pkg;
  localparam logic [7:0] ETH_PRE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam int         PRE_LEN = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_IFG} state_e;
endpackage

// File: rtl/gmii_tx_sched_if.sv
// Per-port byte streams in, one GMII transmit bus out.
interface gmii_tx_sched_if #(
  parameter int PORTS = 2,
  parameter int DW    = 8
);
  logic [PORTS-1:0][DW-1:0] s_tdata;
  logic [PORTS-1:0]         s_tvalid;
  logic [PORTS-1:0]         s_tready;
  logic [PORTS-1:0]         s_tlast;
  logic [PORTS-1:0]         s_tuser;
  logic [DW-1:0]            gmii_d;
  logic                     gmii_en;
  logic                     gmii_er;

  modport master (output s_tdata, s_tvalid, s_tlast, s_tuser,
                  input  s_tready, gmii_d, gmii_en, gmii_er);
  modport slave  (input  s_tdata, s_tvalid, s_tlast, s_tuser,
                  output s_tready, gmii_d, gmii_en, gmii_er);
endinterface

// File: rtl/gmii_tx_sched_rr_arbiter.sv
// Round-robin picker: first requester after the last grant; pointer moves on i_adv.
module rr_arbiter #(
  parameter int PORTS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         i_req,
  input  logic                     i_adv,
  output logic [$clog2(PORTS)-1:0] o_gnt,
  output logic                     o_vld
);
  localparam int GW = $clog2(PORTS);

  logic [GW-1:0] r_last;
  logic [GW-1:0] w_idx;

  always_comb begin
    o_gnt = r_last;
    o_vld = 1'b0;
    w_idx = '0;
    for (int i = 1; i <= PORTS; i++) begin
      w_idx = GW'((int'(r_last) + i) % PORTS);
      if (!o_vld && i_req[w_idx]) begin
        o_gnt = w_idx;
        o_vld = 1'b1;
      end
    end
  end

  // Pointer starts at the last port so port 0 has first priority after reset.
  always_ff @(posedge clk) begin
    if (rst)        r_last <= GW'(PORTS-1);
    else if (i_adv) r_last <= o_gnt;
  end
endmodule

// File: rtl/gmii_tx_sched.sv
// Shares one GMII TX link among PORTS byte streams: RR grant, preamble/SFD, data, IFG.
module gmii_tx_sched import gmii_pkg::*; #(
  parameter int PORTS      = 2,
  parameter int IFG_LEN    = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  gmii_tx_sched_if.slave           bus,
  output logic [$clog2(PORTS)-1:0] grant,
  output logic                     busy,
  output logic                     underrun
);
  localparam int GW = $clog2(PORTS);
  localparam logic [DATA_WIDTH-1:0] IDLE_D = '0;

  state_e                r_state;
  logic [7:0]            r_cnt;
  logic [GW-1:0]         r_grant;
  logic [PORTS-1:0]      r_tready;
  logic [DATA_WIDTH-1:0] r_d;
  logic                  r_en, r_er, r_underrun;

  logic [GW-1:0] w_arb_gnt;
  logic          w_arb_vld, w_start, w_vld;

  assign w_start = (r_state == ST_IDLE) && enable && w_arb_vld;
  assign w_vld   = bus.s_tvalid[r_grant];

  rr_arbiter #(.PORTS(PORTS)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (bus.s_tvalid),
    .i_adv (w_start),
    .o_gnt (w_arb_gnt),
    .o_vld (w_arb_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_tready   <= '0;
      r_d        <= IDLE_D;
      r_en       <= 1'b0;
      r_er       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_d  <= IDLE_D;
          r_en <= 1'b0;
          r_er <= 1'b0;
          if (w_start) begin
            r_state <= ST_PRE;
            r_grant <= w_arb_gnt;
            r_cnt   <= '0;
            r_d     <= ETH_PRE;
            r_en    <= 1'b1;
          end
        end
        // First preamble byte was issued from IDLE; 6 more 0x55 then the SFD.
        ST_PRE: begin
          r_en <= 1'b1;
          r_er <= 1'b0;
          if (r_cnt == 8'(PRE_LEN-2)) begin
            r_d      <= ETH_SFD;
            r_state  <= ST_DATA;
            r_tready <= PORTS'(1) << r_grant;
          end else begin
            r_d   <= ETH_PRE;
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DATA: begin
          r_en <= 1'b1;
          if (w_vld) begin
            r_d  <= bus.s_tdata[r_grant];
            r_er <= bus.s_tuser[r_grant];
            if (bus.s_tlast[r_grant]) begin
              r_state  <= ST_IFG;
              r_tready <= '0;
              r_cnt    <= '0;
            end
          end else begin
            r_d        <= IDLE_D;
            r_er       <= 1'b1;
            r_underrun <= 1'b1;
          end
        end
        // The IDLE cycle that follows contributes the last idle symbol of the gap.
        ST_IFG: begin
          r_d  <= IDLE_D;
          r_en <= 1'b0;
          r_er <= 1'b0;
          if (r_cnt == 8'(IFG_LEN-1)) r_state <= ST_IDLE;
          else                        r_cnt   <= r_cnt + 8'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_tready = r_tready;
  assign bus.gmii_d   = r_d;
  assign bus.gmii_en  = r_en;
  assign bus.gmii_er  = r_er;
  assign grant        = r_grant;
  assign busy         = (r_state != ST_IDLE);
  assign underrun     = r_underrun;
endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed bench for gmii_tx_sched with PORTS=2, IFG_LEN=12.
module tb_gmii_tx_sched;
  typedef struct packed {logic [7:0] d; logic last; logic user;} beat_t;
  typedef struct {int port; int len; int errpos; logic [7:0] base;} vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [0:0] grant;
  logic       busy, underrun;

  gmii_tx_sched_if #(.PORTS(2), .DW(8)) bus ();

  gmii_tx_sched #(.PORTS(2), .IFG_LEN(12), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .bus      (bus.slave),
    .grant    (grant),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  beat_t      q0[$];
  beat_t      q1[$];
  logic [1:0] hold = '0;
  int         n_vec = 0;
  int         n_err = 0;
  vec_t       tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tlast  = '0;
    bus.s_tuser  = '0;
    if (q0.size() > 0) begin
      bus.s_tvalid[0] = !hold[0];
      bus.s_tdata[0]  = q0[0].d;
      bus.s_tlast[0]  = q0[0].last;
      bus.s_tuser[0]  = q0[0].user;
    end
    if (q1.size() > 0) begin
      bus.s_tvalid[1] = !hold[1];
      bus.s_tdata[1]  = q1[0].d;
      bus.s_tlast[1]  = q1[0].last;
      bus.s_tuser[1]  = q1[0].user;
    end
  endtask

  // Handshake is judged on the values present just before the edge.
  task automatic step();
    logic [1:0] acc;
    acc = bus.s_tvalid & bus.s_tready;
    @(posedge clk);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic push_frame(input int p, input int len, input int errpos, input logic [7:0] base);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.d    = base + 8'(b);
      bt.last = (b == len - 1);
      bt.user = (b == errpos);
      if (p == 0) q0.push_back(bt);
      else        q1.push_back(bt);
    end
  endtask

  task automatic check_pre(input int p, input int drop_at);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k + 1 == drop_at) enable = 1'b0;
      chk("pre_d",  bus.gmii_d, (k == 7) ? 32'hD5 : 32'h55);
      chk("pre_en", bus.gmii_en, 1);
      chk("pre_er", bus.gmii_er, 0);
    end
    chk("grant",  grant, p);
    chk("tready", bus.s_tready, 32'(1) << p);
    chk("busy",   busy, 1);
  endtask

  task automatic check_tail(input int len, input int errpos, input logic [7:0] base);
    logic [7:0] exp_d;
    for (int b = 0; b < len; b++) begin
      step();
      exp_d = base + 8'(b);
      chk("data_d",  bus.gmii_d, exp_d);
      chk("data_en", bus.gmii_en, 1);
      chk("data_er", bus.gmii_er, (b == errpos) ? 1 : 0);
      chk("data_ur", underrun, 0);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      chk("ifg_en", bus.gmii_en, 0);
      chk("ifg_er", bus.gmii_er, 0);
      chk("ifg_d",  bus.gmii_d, 0);
    end
    chk("ifg_tready", bus.s_tready, 0);
  endtask

  task automatic check_frame(input int p, input int len, input int errpos, input logic [7:0] base);
    check_pre(p, -1);
    check_tail(len, errpos, base);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 4, -1, 8'h01};
    tbl[1] = '{1, 5,  2, 8'h10};
    tbl[2] = '{0, 1, -1, 8'hA0};
    tbl[3] = '{1, 2,  0, 8'hFF};

    drive();
    step();
    step();
    chk("rst_d",      bus.gmii_d, 0);
    chk("rst_en",     bus.gmii_en, 0);
    chk("rst_er",     bus.gmii_er, 0);
    chk("rst_tready", bus.s_tready, 0);
    chk("rst_grant",  grant, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_ur",     underrun, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      push_frame(tbl[i].port, tbl[i].len, tbl[i].errpos, tbl[i].base);
      drive();
      check_frame(tbl[i].port, tbl[i].len, tbl[i].errpos, tbl[i].base);
      chk("tbl_idle_busy", busy, 0);
    end

    // Both ports loaded: last grant was port 1, so order is 0,1,0 with no extra idle.
    push_frame(0, 3, -1, 8'h20);
    push_frame(1, 3, -1, 8'h30);
    push_frame(0, 3, -1, 8'h40);
    drive();
    check_frame(0, 3, -1, 8'h20);
    check_frame(1, 3, -1, 8'h30);
    check_frame(0, 3, -1, 8'h40);
    chk("rr_busy", busy, 0);

    // Underrun: port 1 stalls two cycles after its first byte.
    push_frame(1, 4, -1, 8'h50);
    drive();
    check_pre(1, -1);
    step();
    chk("ur_b0", bus.gmii_d, 8'h50);
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 2; k++) begin
      step();
      chk("ur_d",     bus.gmii_d, 0);
      chk("ur_en",    bus.gmii_en, 1);
      chk("ur_er",    bus.gmii_er, 1);
      chk("ur_pulse", underrun, 1);
    end
    hold[1] = 1'b0;
    drive();
    check_tail(3, -1, 8'h51);

    // Enable gating, then drop enable during the preamble.
    enable = 1'b0;
    push_frame(0, 3, -1, 8'hC0);
    drive();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("gate_en",   bus.gmii_en, 0);
      chk("gate_busy", busy, 0);
    end
    enable = 1'b1;
    check_pre(0, 3);
    check_tail(3, -1, 8'hC0);
    enable = 1'b1;

    // Reset during byte 2 of a port-0 frame; priority must restart at port 0.
    push_frame(0, 4, -1, 8'h70);
    drive();
    check_pre(0, -1);
    step();
    chk("rs_b0", bus.gmii_d, 8'h70);
    step();
    chk("rs_b1", bus.gmii_d, 8'h71);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_en",     bus.gmii_en, 0);
    chk("rs_er",     bus.gmii_er, 0);
    chk("rs_tready", bus.s_tready, 0);
    chk("rs_busy",   busy, 0);
    chk("rs_grant",  grant, 0);
    chk("rs_ur",     underrun, 0);
    q0.delete();
    q1.delete();
    push_frame(0, 2, -1, 8'h80);
    push_frame(1, 2, -1, 8'h90);
    drive();
    check_frame(0, 2, -1, 8'h80);
    check_frame(1, 2, -1, 8'h90);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
